key_input_ctrl: RTL
===================

// Module: key_input_ctrl
// PURPOSE
//  Input conditioning stage directly upstream of game_control.
//  Turns level-held key states (from the keyboard decoder, already in the clk domain) into one-cycle pulses:
//   - key_left/key_right: delayed auto shift (DAS) with auto-repeat (ARR).
//   - key_down: soft-drop repeat.
//   - rotate/drop/hold: single shot.
//   - key_drop_held: level output.
// PARAMETERS
//  DAS_CYCLES       17_000_000  cycles from initial L/R pulse to first auto-repeat pulse (>=1)
//  ARR_CYCLES        5_000_000  cycles between L/R auto-repeat pulses (>=1; 1 = every cycle)
//  SOFT_ARR_CYCLES   3_000_000  cycles between key_down repeat pulses (>=1)
//  DEBOUNCE_CYCLES     500_000  stable-sample count for the debounce filter (used only with KEY_DEBOUNCE_EN)
// PORTS
//  clk             in   1  system clock
//  rst             in   1  asynchronous, active-high reset
//  enable          in   1  game accepting input; 0 suppresses all outputs
//  raw_left        in   1  left key level
//  raw_right       in   1  right key level
//  raw_down        in   1  down key level
//  raw_rotate_cw   in   1  rotate clockwise key level
//  raw_rotate_ccw  in   1  rotate counter-clockwise key level
//  raw_drop        in   1  hard-drop key level
//  raw_hold        in   1  hold key level
//  key_left        out  1  move-left pulse
//  key_right       out  1  move-right pulse
//  key_down        out  1  soft-drop pulse
//  key_rotate_cw   out  1  rotate-CW pulse
//  key_rotate_ccw  out  1  rotate-CCW pulse
//  key_drop        out  1  hard-drop pulse
//  key_hold        out  1  hold pulse
//  key_drop_held   out  1  registered level: drop key currently held
// BEHAVIOUR
//  - All outputs are registered and reset to 0.
//  - Per-key previous-level registers reset to 1: a key held through reset never fires; it must be released and re-pressed.
//  - Edge latency: filtered level rising at clock edge t gives a pulse high during cycle t+1, width exactly 1 cycle.
//  - Rotate CW/CCW, drop, hold: one pulse per rising edge; holding gives no repeats.
//  - key_drop_held: filtered raw_drop delayed 1 cycle; forced 0 while enable=0.
//  - Horizontal FSM states {IDLE, DAS_WAIT, REPEAT} plus a dir register (L/R).
//    - IDLE, one side rises: immediate pulse on that side; counter loaded with DAS_CYCLES; go to DAS_WAIT.
//    - DAS_WAIT, counter expires: pulse; load ARR_CYCLES; go to REPEAT. Auto pulses land exactly DAS_CYCLES after the initial pulse.
//    - REPEAT: pulse every ARR_CYCLES.
//    - Opposite key rises while one is held: switch dir, immediate pulse, reload DAS, go to DAS_WAIT (last pressed wins).
//    - Both rise in the same cycle: left wins.
//    - Active key released while the other is still held: switch to the other, DAS_WAIT with DAS reloaded, no immediate pulse.
//    - Both released: IDLE, counter cleared.
//  - Down: rising edge gives an immediate pulse, then a pulse every SOFT_ARR_CYCLES while held; no DAS. Release stops it.
//  - Counters are sized $clog2(max param + 1) and never wrap: they reload on expiry and clear when the key is released.
//  - enable=0:
//    - all pulses 0; FSMs forced to IDLE; counters cleared.
//    - previous-level registers keep tracking raw levels, so a key held across the enable rise does not fire.
//  - Reset asserted mid-repeat: outputs 0 immediately (asynchronous); FSMs return to IDLE.
// CONFIGURATION
//  KEY_DEBOUNCE_EN defined:
//   - each raw input passes through a filter whose output changes only after the raw level has been stable for DEBOUNCE_CYCLES consecutive cycles.
//   - filter output resets to 0.
//   - adds DEBOUNCE_CYCLES of latency ahead of the edge logic.
//  KEY_DEBOUNCE_EN undefined: raw inputs feed the edge logic directly; DEBOUNCE_CYCLES is unused.
// TESTING  (DAS=4, ARR=2, SOFT_ARR=3, DEBOUNCE=3; cycle 0 = first edge raw sampled high)
//  1. raw_left high during and after rst release -> no key_left pulse; release, then re-press at 0 -> pulse in cycle 1.
//  2. raw_left held from 0 through cycle 11 -> key_left pulses in cycles 1, 5, 7, 9, 11 only.
//  3. Left held; raw_right rises at 6 -> key_right in 7, 11, 13, no left after 6; release right at 14 -> next key_left in 19.
//  4. raw_down held 0..10 -> key_down in 1, 4, 7, 10; raw_rotate_cw held 20 cycles -> exactly one pulse in cycle 1.
//  5. raw_drop high 0..5 -> key_drop only in cycle 1; key_drop_held high cycles 1..6.
//     enable dropped during left repeat -> no pulses; enable raised with left still held -> no pulse.
//  6. With KEY_DEBOUNCE_EN: 2-cycle raw_hold glitch -> no pulse; raw_hold held 5 cycles from 0 -> key_hold in cycle 4 only.

Source files
------------

// File: rtl/key_input_ctrl.sv
// Key conditioning ahead of game_control: edge pulses, DAS/ARR horizontal repeat, soft-drop repeat.
// Optional raw-input debounce filter is enabled by defining KEY_DEBOUNCE_EN.
module key_input_ctrl #(
  parameter int DAS_CYCLES      = 17_000_000,
  parameter int ARR_CYCLES      = 5_000_000,
  parameter int SOFT_ARR_CYCLES = 3_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_down,
  input  logic raw_rotate_cw,
  input  logic raw_rotate_ccw,
  input  logic raw_drop,
  input  logic raw_hold,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate_cw,
  output logic key_rotate_ccw,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held
);

  localparam int NK    = 7;
  localparam int K_L   = 0;
  localparam int K_R   = 1;
  localparam int K_D   = 2;
  localparam int K_CW  = 3;
  localparam int K_CCW = 4;
  localparam int K_DR  = 5;
  localparam int K_H   = 6;

  localparam int MAX_A = (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
  localparam int MAX_P = (MAX_A > SOFT_ARR_CYCLES) ? MAX_A : SOFT_ARR_CYCLES;
  localparam int CW    = $clog2(MAX_P + 1);

  localparam logic [CW-1:0] DAS_LD  = CW'(DAS_CYCLES);
  localparam logic [CW-1:0] ARR_LD  = CW'(ARR_CYCLES);
  localparam logic [CW-1:0] SOFT_LD = CW'(SOFT_ARR_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic DIR_L = 1'b0;
  localparam logic DIR_R = 1'b1;

  if (DAS_CYCLES < 1 || ARR_CYCLES < 1 || SOFT_ARR_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("key_input_ctrl: all cycle parameters must be >= 1");
  end

  typedef enum logic [1:0] {H_IDLE, H_DAS_WAIT, H_REPEAT} h_state_t;

  logic [NK-1:0] raw_vec;
  logic [NK-1:0] lvl;
  logic [NK-1:0] rise;

  assign raw_vec = {raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw, raw_down, raw_right, raw_left};

`ifdef KEY_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

  // Filter flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
  for (genvar gi = 0; gi < NK; gi++) begin : g_db
    logic [DBW-1:0] cnt_q;
    logic           filt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (raw_vec[gi] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DB_LAST) begin
        cnt_q  <= '0;
        filt_q <= raw_vec[gi];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign lvl[gi] = filt_q;
  end
`else
  assign lvl = raw_vec;
`endif

  // Previous levels start at 1 so a key held through reset needs a fresh press.
  for (genvar gi = 0; gi < NK; gi++) begin : g_edge
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= lvl[gi];
    end

    assign rise[gi] = lvl[gi] & ~prev_q;
  end

  h_state_t      h_state_q, h_state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] d_cnt_q, d_cnt_d;
  logic          pulse_l, pulse_r, pulse_d;
  logic          active_held;

  assign active_held = (dir_q == DIR_R) ? lvl[K_R] : lvl[K_L];

  always_comb begin
    h_state_d = h_state_q;
    dir_d     = dir_q;
    h_cnt_d   = h_cnt_q;
    pulse_l   = 1'b0;
    pulse_r   = 1'b0;
    if (!enable) begin
      h_state_d = H_IDLE;
      h_cnt_d   = '0;
    end else if (rise[K_L]) begin
      dir_d     = DIR_L;
      pulse_l   = 1'b1;
      h_cnt_d   = DAS_LD;
      h_state_d = H_DAS_WAIT;
    end else if (rise[K_R]) begin
      dir_d     = DIR_R;
      pulse_r   = 1'b1;
      h_cnt_d   = DAS_LD;
      h_state_d = H_DAS_WAIT;
    end else if (!lvl[K_L] && !lvl[K_R]) begin
      h_state_d = H_IDLE;
      h_cnt_d   = '0;
    end else if (h_state_q != H_IDLE) begin
      if (!active_held) begin
        // Fall back to the key still held, restarting DAS without a pulse.
        dir_d     = ~dir_q;
        h_cnt_d   = DAS_LD;
        h_state_d = H_DAS_WAIT;
      end else if (h_cnt_q == CNT_ONE) begin
        pulse_l   = (dir_q == DIR_L);
        pulse_r   = (dir_q == DIR_R);
        h_cnt_d   = ARR_LD;
        h_state_d = H_REPEAT;
      end else begin
        h_cnt_d = h_cnt_q - CNT_ONE;
      end
    end
  end

  always_comb begin
    d_cnt_d = d_cnt_q;
    pulse_d = 1'b0;
    if (!enable || !lvl[K_D]) begin
      d_cnt_d = '0;
    end else if (rise[K_D] || d_cnt_q == CNT_ONE) begin
      pulse_d = 1'b1;
      d_cnt_d = SOFT_LD;
    end else if (d_cnt_q != '0) begin
      d_cnt_d = d_cnt_q - CNT_ONE;
    end
  end

  logic key_left_q, key_right_q, key_down_q, key_rotate_cw_q;
  logic key_rotate_ccw_q, key_drop_q, key_hold_q, key_drop_held_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_state_q        <= H_IDLE;
      dir_q            <= DIR_L;
      h_cnt_q          <= '0;
      d_cnt_q          <= '0;
      key_left_q       <= 1'b0;
      key_right_q      <= 1'b0;
      key_down_q       <= 1'b0;
      key_rotate_cw_q  <= 1'b0;
      key_rotate_ccw_q <= 1'b0;
      key_drop_q       <= 1'b0;
      key_hold_q       <= 1'b0;
      key_drop_held_q  <= 1'b0;
    end else begin
      h_state_q        <= h_state_d;
      dir_q            <= dir_d;
      h_cnt_q          <= h_cnt_d;
      d_cnt_q          <= d_cnt_d;
      key_left_q       <= pulse_l;
      key_right_q      <= pulse_r;
      key_down_q       <= pulse_d;
      key_rotate_cw_q  <= enable & rise[K_CW];
      key_rotate_ccw_q <= enable & rise[K_CCW];
      key_drop_q       <= enable & rise[K_DR];
      key_hold_q       <= enable & rise[K_H];
      key_drop_held_q  <= enable & lvl[K_DR];
    end
  end

  assign key_left       = key_left_q;
  assign key_right      = key_right_q;
  assign key_down       = key_down_q;
  assign key_rotate_cw  = key_rotate_cw_q;
  assign key_rotate_ccw = key_rotate_ccw_q;
  assign key_drop       = key_drop_q;
  assign key_hold       = key_hold_q;
  assign key_drop_held  = key_drop_held_q;

endmodule
